tiny_rv_fetch: RTL and testbench

TINY_RV_FETCH -- requirements
Module: tiny_rv_fetch

---
 rtl/tiny_rv_fetch_pkg.sv | 39 +++
 rtl/tiny_rv_fetch_fifo.sv | 82 ++++++++
 rtl/tiny_rv_fetch.sv | 136 +++++++++++++
 tb/tb_tiny_rv_fetch.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/tiny_rv_fetch_pkg.sv
// Shared core package: datapath widths, reset vector default, RV32I base
// opcodes and the fetch-stage types used by the fetch unit and its buffer.
package tiny_rv_fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_VEC_DEFAULT = 32'h0000_0000;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        FETCH_REQ       = 2'd0,
        FETCH_WAIT      = 2'd1,
        FETCH_WAIT_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] next_pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Sequential PC step; wraps naturally modulo 2^32.
    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/tiny_rv_fetch_fifo.sv
// Two-entry FIFO holding fetched {pc, next_pc, instr} records for decode.
// Flush beats push and pop; a push into a full buffer is ignored unless a
// pop frees a slot in the same cycle.
module tiny_rv_fetch_fifo
    import tiny_rv_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push_s;
    logic         do_pop_s;

    assign full  = (count_q == 2'(DEPTH));
    assign empty = (count_q == 2'd0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next-state computation for storage, pointers and occupancy.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_push_s = push && (!full || pop);
        do_pop_s  = pop && !empty;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Buffer state registers; reset clears entries so head reads as zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/tiny_rv_fetch.sv
// Instruction fetch unit: issues one word fetch at a time, buffers up to two
// responses for decode, and handles branch redirects including discarding
// a response that belongs to the abandoned path.
module tiny_rv_fetch
    import tiny_rv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEFAULT,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_addr,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_next_pc,
    output logic [ILEN-1:0] if_instr,
    output logic            misaligned
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            misaligned_q, misaligned_d;

    logic            outstanding_s;
    logic            req_valid_s;
    logic            accept_s;
    logic            push_s;
    logic            pop_s;
    fetch_entry_t    push_data_s;
    fetch_entry_t    head_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [1:0]      fifo_count_s;

    tiny_rv_fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .flush     (br_taken),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .head      (head_s)
    );

    // Request/response handshakes, buffer controls and next-state logic.
    always_comb begin
        outstanding_s = (state_q != FETCH_REQ);
        req_valid_s   = !outstanding_s && !br_taken &&
                        (({1'b0, fifo_count_s} + {2'b00, outstanding_s}) < 3'(BUF_DEPTH));
        accept_s      = req_valid_s && imem_req_ready;
        push_s        = (state_q == FETCH_WAIT) && imem_resp_valid && !br_taken;
        pop_s         = !fifo_empty_s && if_ready && !br_taken;
        push_data_s   = '{pc: req_pc_q, next_pc: pc_inc(req_pc_q), instr: imem_resp_data};
        misaligned_d  = br_taken && (br_addr[1:0] != 2'b00);

        if (br_taken) begin
            fetch_pc_d = {br_addr[XLEN-1:2], 2'b00};
        end else if (accept_s) begin
            fetch_pc_d = pc_inc(fetch_pc_q);
        end else begin
            fetch_pc_d = fetch_pc_q;
        end

        if (accept_s) begin
            req_pc_d = fetch_pc_q;
        end else begin
            req_pc_d = req_pc_q;
        end

        // A response coinciding with the redirect is simply dropped, so only
        // an outstanding request with no response this cycle needs the flag.
        case (state_q)
            FETCH_REQ: begin
                if (accept_s) begin
                    state_d = FETCH_WAIT;
                end else begin
                    state_d = FETCH_REQ;
                end
            end
            FETCH_WAIT: begin
                if (imem_resp_valid) begin
                    state_d = FETCH_REQ;
                end else if (br_taken) begin
                    state_d = FETCH_WAIT_DROP;
                end else begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT_DROP: begin
                if (imem_resp_valid) begin
                    state_d = FETCH_REQ;
                end else begin
                    state_d = FETCH_WAIT_DROP;
                end
            end
            default: state_d = FETCH_REQ;
        endcase
    end

    // Control FSM and fetch address registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= FETCH_REQ;
            fetch_pc_q   <= RESET_VEC;
            req_pc_q     <= RESET_VEC;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = fetch_pc_q;
    assign if_valid       = !fifo_empty_s;
    assign if_pc          = head_s.pc;
    assign if_next_pc     = head_s.next_pc;
    assign if_instr       = head_s.instr;
    assign misaligned     = misaligned_q;

endmodule

// File: tb/tb_tiny_rv_fetch.sv
// Directed, table-driven bench for tiny_rv_fetch. Memory and decode sides
// are driven straight from the vector table, one row per clock cycle.
module tb_tiny_rv_fetch;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        br_taken = 1'b0;
    logic [31:0] br_addr = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_next_pc;
    logic [31:0] if_instr;
    logic        misaligned;

    int n_tests = 0;
    int n_fail  = 0;

    tiny_rv_fetch dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .br_taken        (br_taken),
        .br_addr         (br_addr),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_next_pc      (if_next_pc),
        .if_instr        (if_instr),
        .misaligned      (misaligned)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        ifr;
        logic        br;
        logic [31:0] baddr;
        logic        e_rv;
        logic [31:0] e_raddr;
        logic        e_ifv;
        logic [31:0] e_pc;
        logic [31:0] e_npc;
        logic [31:0] e_instr;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] D0 = 32'h0000_0013;
    localparam logic [31:0] D1 = 32'h0040_0093;
    localparam logic [31:0] D2 = 32'h0080_0113;
    localparam logic [31:0] DX = 32'hDEAD_BEEF;
    localparam logic [31:0] D3 = 32'h1000_0193;
    localparam logic [31:0] D4 = 32'hBAD0_0001;
    localparam logic [31:0] D5 = 32'h0010_0213;
    localparam logic [31:0] D6 = 32'h0020_0293;
    localparam logic [31:0] D7 = 32'h0030_0313;

    task automatic add(input logic rdy, input logic rv, input logic [31:0] rdata,
                       input logic ifr, input logic br, input logic [31:0] baddr,
                       input logic e_rv, input logic [31:0] e_raddr, input logic e_ifv,
                       input logic [31:0] e_pc, input logic [31:0] e_npc,
                       input logic [31:0] e_instr, input logic e_mis);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.ifr = ifr; v.br = br; v.baddr = baddr;
        v.e_rv = e_rv; v.e_raddr = e_raddr; v.e_ifv = e_ifv; v.e_pc = e_pc;
        v.e_npc = e_npc; v.e_instr = e_instr; v.e_mis = e_mis;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rdata,
                         input logic ifr, input logic br, input logic [31:0] baddr);
        imem_req_ready  = rdy;
        imem_resp_valid = rv;
        imem_resp_data  = rdata;
        if_ready        = ifr;
        br_taken        = br;
        br_addr         = baddr;
    endtask

    initial begin
        // rdy rv data ifr br baddr | req_v req_addr if_v pc next_pc instr mis
        add(1, 0, 0,  1, 0, 0,            1, 32'h000, 0, 0, 0, 0, 0);        // c0 first request
        add(1, 1, D0, 1, 0, 0,            0, 32'h004, 0, 0, 0, 0, 0);        // c1 response
        add(1, 0, 0,  1, 0, 0,            1, 32'h004, 1, 32'h0, 32'h4, D0, 0);
        add(1, 1, D1, 1, 0, 0,            0, 32'h008, 0, 0, 0, 0, 0);
        add(1, 0, 0,  0, 0, 0,            1, 32'h008, 1, 32'h4, 32'h8, D1, 0); // stall decode
        add(1, 1, D2, 0, 0, 0,            0, 32'h00C, 1, 32'h4, 32'h8, D1, 0);
        add(1, 0, 0,  0, 0, 0,            0, 32'h00C, 1, 32'h4, 32'h8, D1, 0); // full: no 3rd req
        add(1, 0, 0,  0, 0, 0,            0, 32'h00C, 1, 32'h4, 32'h8, D1, 0);
        add(1, 0, 0,  1, 0, 0,            0, 32'h00C, 1, 32'h4, 32'h8, D1, 0); // drain in order
        add(1, 0, 0,  0, 0, 0,            1, 32'h00C, 1, 32'h8, 32'hC, D2, 0);
        add(1, 0, 0,  0, 1, 32'h100,      0, 32'h010, 1, 32'h8, 32'hC, D2, 0); // redirect, req out
        add(1, 1, DX, 0, 0, 0,            0, 32'h100, 0, 0, 0, 0, 0);        // stale resp dropped
        add(1, 0, 0,  1, 0, 0,            1, 32'h100, 0, 0, 0, 0, 0);
        add(1, 1, D3, 1, 0, 0,            0, 32'h104, 0, 0, 0, 0, 0);
        add(0, 0, 0,  0, 0, 0,            1, 32'h104, 1, 32'h100, 32'h104, D3, 0);
        add(1, 0, 0,  0, 0, 0,            1, 32'h104, 1, 32'h100, 32'h104, D3, 0);
        add(1, 1, D4, 1, 1, 32'h100,      0, 32'h108, 1, 32'h100, 32'h104, D3, 0); // br+resp+pop
        add(1, 0, 0,  1, 0, 0,            1, 32'h100, 0, 0, 0, 0, 0);
        add(1, 1, D5, 1, 0, 0,            0, 32'h104, 0, 0, 0, 0, 0);
        add(0, 0, 0,  1, 0, 0,            1, 32'h104, 1, 32'h100, 32'h104, D5, 0);
        add(1, 0, 0,  1, 1, 32'h102,      0, 32'h104, 0, 0, 0, 0, 0);        // misaligned target
        add(1, 0, 0,  1, 1, 32'h200,      0, 32'h100, 0, 0, 0, 0, 1);        // back-to-back redirect
        add(0, 0, 0,  1, 0, 0,            1, 32'h200, 0, 0, 0, 0, 0);
        add(0, 0, 0,  1, 1, 32'hFFFF_FFFC, 0, 32'h200, 0, 0, 0, 0, 0);
        add(1, 0, 0,  1, 0, 0,            1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);  // wrap
        add(1, 1, D6, 1, 0, 0,            0, 32'h000, 0, 0, 0, 0, 0);
        add(0, 0, 0,  1, 0, 0,            1, 32'h000, 1, 32'hFFFF_FFFC, 32'h0, D6, 0);

        // Reset state, checked while reset is held.
        repeat (2) @(negedge i_clk);
        check("rst if_valid",   {31'd0, if_valid},   32'd0);
        check("rst misaligned", {31'd0, misaligned}, 32'd0);
        check("rst if_pc",      if_pc,               32'h0);
        check("rst if_next_pc", if_next_pc,          32'h0);
        check("rst if_instr",   if_instr,            32'h0);
        check("rst req_addr",   imem_req_addr,       32'h0);

        @(negedge i_clk);
        i_rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge i_clk);
            drive(vecs[i].rdy, vecs[i].rv, vecs[i].rdata, vecs[i].ifr, vecs[i].br, vecs[i].baddr);
            #1;
            check($sformatf("v%0d req_valid", i), {31'd0, imem_req_valid}, {31'd0, vecs[i].e_rv});
            check($sformatf("v%0d req_addr", i),  imem_req_addr,           vecs[i].e_raddr);
            check($sformatf("v%0d if_valid", i),  {31'd0, if_valid},       {31'd0, vecs[i].e_ifv});
            check($sformatf("v%0d misaligned", i), {31'd0, misaligned},    {31'd0, vecs[i].e_mis});
            if (vecs[i].e_ifv) begin
                check($sformatf("v%0d if_pc", i),      if_pc,      vecs[i].e_pc);
                check($sformatf("v%0d if_next_pc", i), if_next_pc, vecs[i].e_npc);
                check($sformatf("v%0d if_instr", i),   if_instr,   vecs[i].e_instr);
            end
        end

        // Reset in the middle of an outstanding request.
        @(negedge i_clk);
        drive(1, 0, 0, 0, 0, 0);                    // request 0x0 accepted
        #1 check("h1 req_addr", imem_req_addr, 32'h0);
        @(negedge i_clk);
        drive(0, 1, D7, 0, 0, 0);                   // response buffered
        @(negedge i_clk);
        drive(1, 0, 0, 0, 0, 0);                    // request 0x4 accepted
        #1 check("h3 if_pc", if_pc, 32'h0);
        check("h3 req_addr", imem_req_addr, 32'h4);
        @(negedge i_clk);
        drive(0, 0, 0, 0, 0, 0);
        #1 check("h4 outstanding", {31'd0, imem_req_valid}, 32'd0);
        #1 i_rst = 1'b1;                            // asynchronous, between edges
        #1 check("h4 async if_valid", {31'd0, if_valid}, 32'd0);
        check("h4 async req_addr", imem_req_addr, 32'h0);
        check("h4 async if_instr", if_instr, 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        drive(0, 1, DX, 1, 0, 0);                   // stale response after reset
        #1 check("h5 req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("h5 req_addr", imem_req_addr, 32'h0);
        @(negedge i_clk);
        drive(0, 0, 0, 1, 0, 0);
        #1 check("h6 if_valid", {31'd0, if_valid}, 32'd0);
        check("h6 req_valid", {31'd0, imem_req_valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
